// File: rtl/secuenciador_registro_pkg.sv
// Shared sizing, state encoding and index helper for the capture/playback sequencer.
package secuenciador_registro_pkg;

    localparam int N_DEF   = 32;
    localparam int TMO_DEF = 4;
    localparam int IDX_W   = $clog2(N_DEF);
    localparam int CNT_W   = IDX_W + 1;
    localparam int DATA_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        LEER,
        ESPERA,
        SALIDA
    } state_t;

    // Circular successor of a store index for a buffer of depth n.
    function automatic logic [IDX_W-1:0] idx_siguiente(input logic [IDX_W-1:0] idx, input int n);
        return (idx == IDX_W'(n - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/secuenciador_registro.sv
// Capture/playback sequencer for an external circular register store: forwards captures
// as write strobes and replays the stored samples oldest-first through a valid/ready port.
module secuenciador_registro
    import secuenciador_registro_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_dato,
    output logic              cap_ready,
    input  logic              play_start,
    input  logic              play_abort,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_dato,
    input  logic              out_ready,
    output logic              play_busy,
    output logic              play_done,
    output logic              err_lectura,
    output logic              reg_iniciar,
    output logic [DATA_W-1:0] reg_dato,
    output logic              leer_ahora,
    output logic [IDX_W-1:0]  leer_index,
    input  logic [IDX_W-1:0]  reg_posicion,
    input  logic [CNT_W-1:0]  reg_contador,
    input  logic [DATA_W-1:0] leer_data,
    input  logic              valor_leer_listo
);

    localparam int               TMO_W    = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);

    state_t            r_state, w_state_next;
    logic              r_pending, w_pending_next;
    logic [CNT_W-1:0]  r_restante, w_restante_next;
    logic [IDX_W-1:0]  r_idx, w_idx_next;
    logic [TMO_W-1:0]  r_tmo_cnt, w_tmo_cnt_next;
    logic              r_out_valid, w_out_valid_next;
    logic [DATA_W-1:0] r_out_dato, w_out_dato_next;
    logic              r_play_done, w_play_done_next;
    logic              r_err, w_err_next;
    logic              r_cap_ready;
    logic              r_reg_iniciar;
    logic [DATA_W-1:0] r_reg_dato;
    logic              w_cap_acc;
    logic              w_pend_eff;

    // cap_ready is registered so it stays low while reset is held and rises one edge later.
    assign w_cap_acc  = cap_valid && r_cap_ready;
    assign w_pend_eff = r_pending || play_start;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latch).
        w_state_next     = r_state;
        w_pending_next   = r_pending;
        w_restante_next  = r_restante;
        w_idx_next       = r_idx;
        w_tmo_cnt_next   = r_tmo_cnt;
        w_out_valid_next = r_out_valid;
        w_out_dato_next  = r_out_dato;
        w_play_done_next = 1'b0;
        w_err_next       = r_err;

        if (r_state != IDLE && play_abort) begin
            w_state_next     = IDLE;
            w_out_valid_next = 1'b0;
            w_pending_next   = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // A write still in flight must land in the store before the count is snapshotted.
                    if (w_pend_eff && !cap_valid && !r_reg_iniciar) begin
                        w_state_next   = SNAP;
                        w_pending_next = 1'b0;
                    end else begin
                        w_pending_next = w_pend_eff;
                    end
                end
                SNAP: begin
                    w_restante_next = reg_contador;
                    w_idx_next      = (reg_contador < CNT_FULL) ? '0 : reg_posicion;
                    if (reg_contador == '0) begin
                        w_state_next     = IDLE;
                        w_play_done_next = 1'b1;
                    end else begin
                        w_state_next = LEER;
                    end
                end
                LEER: begin
                    w_tmo_cnt_next = '0;
                    w_state_next   = ESPERA;
                end
                ESPERA: begin
                    if (valor_leer_listo) begin
                        w_out_dato_next  = leer_data;
                        w_out_valid_next = 1'b1;
                        w_state_next     = SALIDA;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        w_err_next   = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
                    end
                end
                SALIDA: begin
                    if (out_ready) begin
                        w_out_valid_next = 1'b0;
                        w_restante_next  = r_restante - CNT_W'(1);
                        if (r_restante == CNT_W'(1)) begin
                            w_state_next     = IDLE;
                            w_play_done_next = 1'b1;
                        end else begin
                            w_idx_next   = idx_siguiente(r_idx, N);
                            w_state_next = LEER;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pending     <= 1'b0;
            r_restante    <= '0;
            r_idx         <= '0;
            r_tmo_cnt     <= '0;
            r_out_valid   <= 1'b0;
            r_out_dato    <= '0;
            r_play_done   <= 1'b0;
            r_err         <= 1'b0;
            r_cap_ready   <= 1'b0;
            r_reg_iniciar <= 1'b0;
            r_reg_dato    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pending     <= w_pending_next;
            r_restante    <= w_restante_next;
            r_idx         <= w_idx_next;
            r_tmo_cnt     <= w_tmo_cnt_next;
            r_out_valid   <= w_out_valid_next;
            r_out_dato    <= w_out_dato_next;
            r_play_done   <= w_play_done_next;
            r_err         <= w_err_next;
            r_cap_ready   <= (w_state_next == IDLE);
            r_reg_iniciar <= w_cap_acc;
            if (w_cap_acc) begin
                r_reg_dato <= cap_dato;
            end
        end
    end

    assign cap_ready   = r_cap_ready;
    assign out_valid   = r_out_valid;
    assign out_dato    = r_out_dato;
    assign play_busy   = (r_state != IDLE);
    assign play_done   = r_play_done;
    assign err_lectura = r_err;
    assign reg_iniciar = r_reg_iniciar;
    assign reg_dato    = r_reg_dato;
    assign leer_ahora  = (r_state == LEER);
    assign leer_index  = (r_state == LEER) ? r_idx : '0;

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(leer_ahora && reg_iniciar));

    a_out_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready && !play_abort) |=> (out_valid && $stable(out_dato)));

endmodule

// File: doc/secuenciador_registro.md
SECUENCIADOR_REGISTRO -- requirements
Module: secuenciador_registro

Interface
REQ-001 Parameters SHALL be: N, default 32, buffer depth of the attached register store; TMO, default 4, max cycles waiting for read data.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be, one per line:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
cap_valid  in  1  capture request
cap_dato  in  16  sample to store
cap_ready  out  1  capture accepted when high with cap_valid
play_start  in  1  1-cycle pulse, start oldest-first playback
play_abort  in  1  abort playback
out_valid  out  1  playback sample valid
out_dato  out  16  playback sample
out_ready  in  1  consumer accepts out_dato
play_busy  out  1  high in any non-IDLE state
play_done  out  1  1-cycle pulse, playback completed
err_lectura  out  1  sticky read-timeout flag
reg_iniciar  out  1  write strobe to store
reg_dato  out  16  write data to store
leer_ahora  out  1  read strobe to store
leer_index  out  5  read index
reg_posicion  in  5  store next-write position
reg_contador  in  6  store fill count, 0..N
leer_data  in  16  store read data
valor_leer_listo  in  1  store read-data valid

Function
REQ-004 FSM states SHALL be IDLE, SNAP, LEER, ESPERA, SALIDA.
REQ-005 cap_ready SHALL be 1 only in IDLE; accepted capture at cycle t SHALL give reg_iniciar=1, reg_dato=cap_dato at t+1 for exactly one cycle; back-to-back captures allowed.
REQ-006 In IDLE, play_start SHALL set a pending flag; when cap_valid=1 in the same cycle, the capture is accepted and the start stays pending.
REQ-007 IDLE->SNAP SHALL occur when pending=1, cap_valid=0 and reg_iniciar=0 (no write in flight); pending clears on entry.
REQ-008 SNAP SHALL latch restante=reg_contador and idx=(reg_contador<N)?0:reg_posicion; if reg_contador=0, go IDLE and pulse play_done next cycle; else go LEER.
REQ-009 LEER SHALL drive leer_ahora=1, leer_index=idx for one cycle, then go ESPERA.
REQ-010 ESPERA SHALL, on valor_leer_listo=1, register out_dato=leer_data, set out_valid=1 and go SALIDA; after TMO cycles without it, set err_lectura=1 and go IDLE without play_done.
REQ-011 SALIDA SHALL hold out_valid and out_dato stable until out_ready=1; on handshake out_valid drops next cycle, restante decrements; restante=1 -> IDLE plus play_done pulse; else idx=(idx==N-1)?0:idx+1, go LEER.
REQ-012 play_abort in SNAP/LEER/ESPERA/SALIDA SHALL force IDLE next cycle, out_valid=0, no play_done, pending cleared; abort has priority over every other transition.
REQ-013 play_start outside IDLE SHALL be ignored; leer_ahora and reg_iniciar SHALL never be high in the same cycle.
REQ-014 err_lectura SHALL clear only on reset.

Reset
REQ-015 reset_n=0 at a rising edge SHALL give state IDLE, pending=0, restante=0, idx=0, and all outputs 0 (cap_ready becomes 1 the cycle after reset_n rises), including mid-playback.

Structure
REQ-016 A shared package SHALL hold the state enum, default N, default TMO, index width ($clog2 N = 5) and data width 16.
REQ-017 The module SHALL be flat, with no sub-module; the store is instantiated beside it by the integrating top.

Verification
REQ-018 Captures 0x0011,0x0022,0x0033 then play_start, out_ready=1 -> out_dato 0x0011,0x0022,0x0033 in order, play_done once, reads at indices 0,1,2.
REQ-019 Capture 35 samples 1..35 (N=32), play -> out_dato 4..35, first leer_index=3, wrap 31->0 observed.
REQ-020 play_start with reg_contador=0 -> no leer_ahora, play_done 2 cycles later.
REQ-021 play_start coincident with cap_valid (0x00AA) -> capture written first, playback includes 0x00AA as last sample.
REQ-022 out_ready held 0 for 5 cycles in SALIDA -> out_dato stable, no new leer_ahora; then play_abort -> IDLE, play_done never asserted.
REQ-023 valor_leer_listo tied 0 -> err_lectura=1 after TMO=4 cycles in ESPERA, IDLE, remains set until reset_n=0.
